// File: rtl/mon_fifo_ctrl.sv
// Pointer manager and write/read arbiter for the monitor data FIFO.
// Captures pass through a one-entry skid; pops are single-word and never overlap.
module mon_fifo_ctrl #(
    parameter int AW = 11,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst_x,
    input  logic          clr,
    input  logic          cap_valid,
    input  logic [DW-1:0] cap_data,
    input  logic          rd_req,
    output logic          rd_busy,
    output logic          rd_valid,
    output logic          rd_nack,
    output logic [DW-1:0] rd_data,
    output logic          fifo_wrreq,
    output logic [AW-1:0] fifo_waddr,
    output logic [DW-1:0] fifo_wdata,
    output logic          fifo_rdreq,
    output logic [AW-1:0] fifo_raddr,
    input  logic [DW-1:0] fifo_rdata,
    output logic [AW-1:0] level,
    output logic [15:0]   ovf_cnt
);

    typedef enum logic {
        SIDE_RD = 1'b0,
        SIDE_WR = 1'b1
    } side_e;

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic          hold_vld_q, hold_vld_d;
    logic [DW-1:0] hold_data_q, hold_data_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_out_q, rd_out_d;
    logic          nack_q, nack_d;
    side_e         last_w_q, last_w_d;
    logic [15:0]   ovf_cnt_q, ovf_cnt_d;

    logic [AW-1:0] wptr_inc;
    logic          empty, full;
    logic          w_req, r_req, discard, contested;
    logic          w_gnt, r_gnt;
    logic          hold_free, drop_cap, pop_accept;
    logic [16:0]   ovf_sum;

    // Grants depend on registered state only, so the RAM request ports have no input path.
    always_comb begin
        wptr_inc  = wptr_q + 1'b1;
        empty     = (rptr_q == wptr_q);
        full      = (rptr_q == wptr_inc);
        w_req     = hold_vld_q & ~full;
        discard   = hold_vld_q & full;
        r_req     = rd_pend_q;
        contested = w_req & r_req;
        w_gnt     = w_req & (~r_req | (last_w_q == SIDE_RD));
        r_gnt     = r_req & ~w_gnt;
        hold_free = ~hold_vld_q | w_gnt | discard;
        drop_cap  = cap_valid & ~hold_free;
        pop_accept = rd_req & ~(rd_pend_q | rd_out_q);
        ovf_sum   = {1'b0, ovf_cnt_q} + {16'd0, drop_cap} + {16'd0, discard};
    end

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        rd_pend_d   = rd_pend_q;
        rd_out_d    = 1'b0;
        nack_d      = 1'b0;
        last_w_d    = last_w_q;
        ovf_cnt_d   = ovf_cnt_q;
        if (clr) begin
            wptr_d      = '0;
            rptr_d      = '0;
            hold_vld_d  = 1'b0;
            hold_data_d = '0;
            rd_pend_d   = 1'b0;
            last_w_d    = SIDE_RD;
            ovf_cnt_d   = '0;
        end else begin
            if (w_gnt) wptr_d = wptr_inc;
            if (r_gnt) begin
                rptr_d    = rptr_q + 1'b1;
                rd_pend_d = 1'b0;
            end
            rd_out_d = r_gnt;
            if (pop_accept && !empty) rd_pend_d = 1'b1;
            nack_d = pop_accept & empty;
            if (cap_valid && hold_free) begin
                hold_vld_d  = 1'b1;
                hold_data_d = cap_data;
            end else if (hold_free) begin
                hold_vld_d = 1'b0;
            end
            if (contested) last_w_d = w_gnt ? SIDE_WR : SIDE_RD;
            ovf_cnt_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_out_q    <= 1'b0;
            nack_q      <= 1'b0;
            last_w_q    <= SIDE_RD;
            ovf_cnt_q   <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            rd_pend_q   <= rd_pend_d;
            rd_out_q    <= rd_out_d;
            nack_q      <= nack_d;
            last_w_q    <= last_w_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // A flush in the delivery cycle also cancels the response that was about to appear.
    assign rd_valid   = rd_out_q & ~clr;
    assign rd_nack    = nack_q & ~clr;
    assign rd_data    = rd_out_q ? fifo_rdata : '0;
    assign rd_busy    = rd_pend_q | rd_out_q;
    assign fifo_wrreq = w_gnt;
    assign fifo_waddr = wptr_q;
    assign fifo_wdata = hold_data_q;
    assign fifo_rdreq = r_gnt;
    assign fifo_raddr = rptr_q;
    assign level      = wptr_q - rptr_q;
    assign ovf_cnt    = ovf_cnt_q;

endmodule

// File: tb/tb_mon_fifo_ctrl.sv
// Directed bench for mon_fifo_ctrl: a RAM model, a cycle-level scoreboard on the
// falling edge, and directed checks of reset, fill/overflow, flush, contention and wrap.
module tb_mon_fifo_ctrl;

    localparam int AW = 11;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          rst_x, clr, cap_valid, rd_req;
    logic [DW-1:0] cap_data;
    logic          rd_busy, rd_valid, rd_nack, fifo_wrreq, fifo_rdreq;
    logic [DW-1:0] rd_data, fifo_wdata, fifo_rdata;
    logic [AW-1:0] fifo_waddr, fifo_raddr, level;
    logic [15:0]   ovf_cnt;

    always #5 clk = ~clk;

    mon_fifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_x(rst_x), .clr(clr),
        .cap_valid(cap_valid), .cap_data(cap_data),
        .rd_req(rd_req), .rd_busy(rd_busy), .rd_valid(rd_valid),
        .rd_nack(rd_nack), .rd_data(rd_data),
        .fifo_wrreq(fifo_wrreq), .fifo_waddr(fifo_waddr), .fifo_wdata(fifo_wdata),
        .fifo_rdreq(fifo_rdreq), .fifo_raddr(fifo_raddr), .fifo_rdata(fifo_rdata),
        .level(level), .ovf_cnt(ovf_cnt)
    );

    // Synchronous RAM with one-cycle read latency.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    always @(posedge clk) begin
        if (fifo_wrreq) ram[fifo_waddr] <= fifo_wdata;
        if (fifo_rdreq) ram_q <= ram[fifo_raddr];
    end
    assign fifo_rdata = ram_q;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard state: pointers, skip entry, pending pop, and the words stored in write order.
    bit            m_ok = 1'b0;
    logic [AW-1:0] m_wptr, m_rptr, m_level;
    bit            m_hold_vld, m_pend, m_out, m_nack, m_last_known, m_last_wr;
    logic [DW-1:0] m_hold, m_rd_exp;
    int            m_ovf;
    logic [DW-1:0] m_stored[$];
    bit            m_full, m_empty, m_wreq, m_rreq, m_disc, m_free, m_busy;
    int            m_drops;

    always @(negedge clk) begin
        m_full  = (m_rptr == (m_wptr + 1'b1));
        m_empty = (m_rptr == m_wptr);
        m_wreq  = m_hold_vld && !m_full;
        m_rreq  = m_pend;
        m_busy  = m_pend || m_out;
        m_level = m_wptr - m_rptr;
        if (m_ok && rst_x) begin
            check("level", level, m_level);
            check("rd_busy", rd_busy, m_busy);
            check("rd_valid", rd_valid, m_out && !clr);
            check("rd_nack", rd_nack, m_nack && !clr);
            check("ovf_cnt", ovf_cnt, m_ovf);
            check("no_dual_grant", fifo_wrreq && fifo_rdreq, 0);
            if (m_wreq && m_rreq) begin
                check("contested_one_grant", fifo_wrreq ^ fifo_rdreq, 1);
                if (m_last_known) check("contested_alternate", fifo_wrreq, !m_last_wr);
            end else begin
                check("wrreq", fifo_wrreq, m_wreq);
                check("rdreq", fifo_rdreq, m_rreq);
            end
            if (fifo_wrreq) begin
                check("waddr", fifo_waddr, m_wptr);
                check("wdata", fifo_wdata, m_hold);
            end
            if (fifo_rdreq) check("raddr", fifo_raddr, m_rptr);
            if (rd_valid) check("rd_data", rd_data, m_rd_exp);
        end
        if (!rst_x || clr) begin
            m_ok = 1'b1;
            m_wptr = '0; m_rptr = '0; m_hold_vld = 0; m_hold = '0;
            m_pend = 0; m_out = 0; m_nack = 0; m_last_known = 0; m_last_wr = 0;
            m_ovf = 0;
            m_stored.delete();
        end else if (m_ok) begin
            m_disc  = m_hold_vld && m_full;
            m_free  = !m_hold_vld || fifo_wrreq || m_disc;
            m_drops = int'(m_disc) + int'(cap_valid && !m_free);
            m_ovf   = (m_ovf + m_drops > 65535) ? 65535 : m_ovf + m_drops;
            if (m_wreq && m_rreq) begin
                m_last_known = 1;
                m_last_wr    = fifo_wrreq;
            end
            if (fifo_wrreq) begin
                m_stored.push_back(m_hold);
                m_wptr = m_wptr + 1'b1;
            end
            if (cap_valid && m_free) begin
                m_hold_vld = 1;
                m_hold     = cap_data;
            end else if (m_free) begin
                m_hold_vld = 0;
            end
            if (fifo_rdreq) begin
                if (m_stored.size() > 0) m_rd_exp = m_stored.pop_front();
                m_rptr = m_rptr + 1'b1;
                m_pend = 0;
            end
            m_out  = fifo_rdreq;
            m_nack = 0;
            if (rd_req && !m_busy) begin
                if (m_empty) m_nack = 1;
                else         m_pend = 1;
            end
        end
    end

    task automatic drive(input logic cv, input logic [DW-1:0] cd, input logic rq, input logic cl);
        cap_valid = cv;
        cap_data  = cd;
        rd_req    = rq;
        clr       = cl;
        @(posedge clk);
        #1;
        cap_valid = 1'b0;
        rd_req    = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before the sequence completed");
        summary();
        $fatal(1, "watchdog");
    end

    int  n_rd_wins, n_cap, n_valid;
    bit  cv;

    initial begin
        rst_x = 1'b0; clr = 1'b0; cap_valid = 1'b0; cap_data = '0; rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_x = 1'b1;

        // Reset state
        check("rst_rd_busy", rd_busy, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_nack", rd_nack, 0);
        check("rst_wrreq", fifo_wrreq, 0);
        check("rst_rdreq", fifo_rdreq, 0);
        check("rst_waddr", fifo_waddr, 0);
        check("rst_raddr", fifo_raddr, 0);
        check("rst_level", level, 0);
        check("rst_ovf", ovf_cnt, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_wdata", fifo_wdata, 0);

        // Single word round trip
        drive(1, 18'h2A5A5, 0, 0);
        check("single_wrreq", fifo_wrreq, 1);
        check("single_waddr", fifo_waddr, 0);
        check("single_wdata", fifo_wdata, 18'h2A5A5);
        drive(0, '0, 0, 0);
        check("single_wrreq_once", fifo_wrreq, 0);
        check("single_level1", level, 1);
        drive(0, '0, 1, 0);
        check("single_rdreq", fifo_rdreq, 1);
        check("single_raddr", fifo_raddr, 0);
        check("single_busy", rd_busy, 1);
        drive(0, '0, 0, 0);
        check("single_rd_valid", rd_valid, 1);
        check("single_rd_data", rd_data, 18'h2A5A5);
        check("single_level0", level, 0);
        drive(0, '0, 0, 0);
        check("single_valid_pulse", rd_valid, 0);
        check("single_busy_clear", rd_busy, 0);

        // Pop from empty
        drive(0, '0, 1, 0);
        check("empty_nack", rd_nack, 1);
        check("empty_no_rdreq", fifo_rdreq, 0);
        check("empty_no_valid", rd_valid, 0);
        drive(0, '0, 0, 0);
        check("empty_nack_pulse", rd_nack, 0);
        check("empty_no_rdreq2", fifo_rdreq, 0);

        // Fill to capacity and overflow
        drive(0, '0, 0, 1);
        for (int i = 0; i < 2050; i++) drive(1, DW'(i), 0, 0);
        drive(0, '0, 0, 0);
        check("fill_level", level, 2047);
        check("fill_ovf", ovf_cnt, 2050 - 2047);
        check("fill_idle", fifo_wrreq, 0);

        // Write address wraps 0x7FF -> 0x000
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);
        check("wrap_first_word", rd_data, 0);
        drive(1, 18'h01234, 0, 0);
        check("wrap_wrreq_7ff", fifo_wrreq, 1);
        check("wrap_waddr_7ff", fifo_waddr, 11'h7FF);
        drive(0, '0, 1, 0);
        drive(0, '0, 0, 0);
        drive(1, 18'h0BEEF, 0, 0);
        check("wrap_wrreq_000", fifo_wrreq, 1);
        check("wrap_waddr_000", fifo_waddr, 11'h000);
        drive(0, '0, 0, 0);
        check("wrap_level", level, 2047);

        // Flush in the cycle after a read grant
        drive(0, '0, 1, 0);
        check("flush_grant", fifo_rdreq, 1);
        drive(0, '0, 0, 0);
        clr = 1'b1;
        #2;
        check("flush_valid_suppressed", rd_valid, 0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        check("flush_no_valid", rd_valid, 0);
        check("flush_level", level, 0);
        check("flush_ovf", ovf_cnt, 0);
        check("flush_busy", rd_busy, 0);
        drive(1, 18'h3C3C3, 0, 0);
        check("flush_wrreq", fifo_wrreq, 1);
        check("flush_waddr", fifo_waddr, 0);
        drive(0, '0, 0, 0);

        // Contention: continuous captures with pops whenever idle
        drive(0, '0, 0, 1);
        for (int i = 0; i < 11; i++) drive(1, DW'($urandom), 0, 0);
        check("cont_level10", level, 10);
        n_rd_wins = 0;
        for (int i = 0; i < 300; i++) begin
            if (fifo_rdreq) n_rd_wins++;
            drive(1, DW'($urandom), !rd_busy, 0);
        end
        check("cont_ovf_equals_read_wins", ovf_cnt, n_rd_wins);
        check("cont_pops_served", n_rd_wins > 40, 1);
        for (int i = 0; i < 4000 && (level != 0 || rd_busy); i++) drive(0, '0, !rd_busy, 0);
        check("cont_drained", (level == 0) && !rd_busy, 1);

        // Interleaved traffic across both pointer wraps
        drive(0, '0, 0, 1);
        n_cap = 0;
        n_valid = 0;
        for (int i = 0; i < 20000 && n_cap < 3000; i++) begin
            if (rd_valid) n_valid++;
            cv = (i % 4 == 0);
            drive(cv, DW'($urandom), !rd_busy, 0);
            if (cv) n_cap++;
        end
        for (int i = 0; i < 200 && (n_valid < 3000 || rd_busy); i++) begin
            if (rd_valid) n_valid++;
            drive(0, '0, !rd_busy, 0);
        end
        check("ptrwrap_captures", n_cap, 3000);
        check("ptrwrap_words_out", n_valid, 3000);
        check("ptrwrap_ovf", ovf_cnt, 0);
        check("ptrwrap_level", level, 0);

        summary();
        $finish;
    end

endmodule
